// File: rtl/axi4_lite_cmd_mst_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axi4_lite_cmd_mst_pkg;

    // Transaction sequencer states; one transaction in flight at most.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

    // AXI response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Protection attributes: unprivileged, secure, data access.
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // Width of the completed-transaction counters.
    localparam int CNT_W = 16;

    // Decoded command-side handshake.
    typedef struct packed {
        logic fire;
        logic we;
    } cmd_ctl_t;

    // Response-side control bits returned to the command issuer.
    typedef struct packed {
        logic       valid;
        logic       we;
        logic [1:0] resp;
    } rsp_ctl_t;

    // True for the two error response codes.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_cmd_mst.sv
// AXI4-Lite master that turns single commands into bus transactions,
// one at a time, and returns one response per command.
module axi4_lite_cmd_mst
    import axi4_lite_cmd_mst_pkg::*;
#(
    parameter int AXI4_LITE_ADDR_BIT_WIDTH = 4,
    parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_sync_rst,
    input  logic                                  i_cmd_valid,
    output logic                                  o_cmd_ready,
    input  logic                                  i_cmd_we,
    input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
    input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
    input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
    output logic                                  o_rsp_valid,
    input  logic                                  i_rsp_ready,
    output logic                                  o_rsp_we,
    output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                            o_rsp_resp,
    output logic [CNT_W-1:0]                      o_wr_cnt,
    output logic [CNT_W-1:0]                      o_rd_cnt,
    axi4_lite_if.master                           if_m_axi4_lite
);

    localparam int AW = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int DW = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int SW = AXI4_LITE_DATA_BIT_WIDTH / 8;

    state_e           state_r,     state_s;
    logic             cmd_ready_r, cmd_ready_s;
    logic             awvalid_r,   awvalid_s;
    logic             wvalid_r,    wvalid_s;
    logic             bready_r,    bready_s;
    logic             arvalid_r,   arvalid_s;
    logic             rready_r,    rready_s;
    logic [AW-1:0]    addr_r,      addr_s;
    logic [DW-1:0]    wdata_r,     wdata_s;
    logic [SW-1:0]    wstrb_r,     wstrb_s;
    rsp_ctl_t         rsp_r,       rsp_s;
    logic [DW-1:0]    rsp_rdata_r, rsp_rdata_s;
    logic [CNT_W-1:0] wr_cnt_r,    wr_cnt_s;
    logic [CNT_W-1:0] rd_cnt_r,    rd_cnt_s;

    cmd_ctl_t         cmd_s;
    logic             aw_pend_s;
    logic             w_pend_s;

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_s     = state_r;
        awvalid_s   = awvalid_r;
        wvalid_s    = wvalid_r;
        bready_s    = bready_r;
        arvalid_s   = arvalid_r;
        rready_s    = rready_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        wstrb_s     = wstrb_r;
        rsp_s       = rsp_r;
        rsp_rdata_s = rsp_rdata_r;
        wr_cnt_s    = wr_cnt_r;
        rd_cnt_s    = rd_cnt_r;

        cmd_s.fire  = i_cmd_valid & cmd_ready_r;
        cmd_s.we    = i_cmd_we;
        // A channel is still pending if it was offered and not taken this edge.
        aw_pend_s   = awvalid_r & ~if_m_axi4_lite.awready;
        w_pend_s    = wvalid_r  & ~if_m_axi4_lite.wready;

        case (state_r)
            ST_IDLE: begin
                if (cmd_s.fire) begin
                    addr_s  = i_cmd_addr;
                    wdata_s = i_cmd_wdata;
                    wstrb_s = i_cmd_wstrb;
                    if (cmd_s.we) begin
                        awvalid_s = 1'b1;
                        wvalid_s  = 1'b1;
                        state_s   = ST_WR;
                    end else begin
                        arvalid_s = 1'b1;
                        state_s   = ST_RD_ADDR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR: begin
                // Address and data channels retire independently.
                awvalid_s = aw_pend_s;
                wvalid_s  = w_pend_s;
                if (!aw_pend_s && !w_pend_s) begin
                    bready_s = 1'b1;
                    state_s  = ST_WR_RESP;
                end else begin
                    state_s  = ST_WR;
                end
            end
            ST_WR_RESP: begin
                if (if_m_axi4_lite.bvalid && bready_r) begin
                    bready_s    = 1'b0;
                    rsp_s.valid = 1'b1;
                    rsp_s.we    = 1'b1;
                    rsp_s.resp  = if_m_axi4_lite.bresp;
                    rsp_rdata_s = {DW{1'b0}};
                    wr_cnt_s    = wr_cnt_r + 16'd1;
                    state_s     = ST_RSP;
                end else begin
                    state_s     = ST_WR_RESP;
                end
            end
            ST_RD_ADDR: begin
                if (arvalid_r && if_m_axi4_lite.arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = ST_RD_DATA;
                end else begin
                    state_s   = ST_RD_ADDR;
                end
            end
            ST_RD_DATA: begin
                if (if_m_axi4_lite.rvalid && rready_r) begin
                    rready_s    = 1'b0;
                    rsp_s.valid = 1'b1;
                    rsp_s.we    = 1'b0;
                    rsp_s.resp  = if_m_axi4_lite.rresp;
                    rsp_rdata_s = if_m_axi4_lite.rdata;
                    rd_cnt_s    = rd_cnt_r + 16'd1;
                    state_s     = ST_RSP;
                end else begin
                    state_s     = ST_RD_DATA;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    rsp_s.valid = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s     = ST_RSP;
                end
            end
            default: begin
                awvalid_s   = 1'b0;
                wvalid_s    = 1'b0;
                bready_s    = 1'b0;
                arvalid_s   = 1'b0;
                rready_s    = 1'b0;
                rsp_s.valid = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase

        // Ready is registered so it is only ever high while sitting in IDLE,
        // which also keeps it low on the cycle a response is consumed.
        cmd_ready_s = (state_s == ST_IDLE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            addr_r      <= {AW{1'b0}};
            wdata_r     <= {DW{1'b0}};
            wstrb_r     <= {SW{1'b0}};
            rsp_r       <= '{valid: 1'b0, we: 1'b0, resp: RESP_OKAY};
            rsp_rdata_r <= {DW{1'b0}};
            wr_cnt_r    <= 16'd0;
            rd_cnt_r    <= 16'd0;
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= cmd_ready_s;
            awvalid_r   <= awvalid_s;
            wvalid_r    <= wvalid_s;
            bready_r    <= bready_s;
            arvalid_r   <= arvalid_s;
            rready_r    <= rready_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            wstrb_r     <= wstrb_s;
            rsp_r       <= rsp_s;
            rsp_rdata_r <= rsp_rdata_s;
            wr_cnt_r    <= wr_cnt_s;
            rd_cnt_r    <= rd_cnt_s;
        end
    end

    assign o_cmd_ready = cmd_ready_r;
    assign o_rsp_valid = rsp_r.valid;
    assign o_rsp_we    = rsp_r.we;
    assign o_rsp_resp  = rsp_r.resp;
    assign o_rsp_rdata = rsp_rdata_r;
    assign o_wr_cnt    = wr_cnt_r;
    assign o_rd_cnt    = rd_cnt_r;

    assign if_m_axi4_lite.awvalid = awvalid_r;
    assign if_m_axi4_lite.awaddr  = addr_r;
    assign if_m_axi4_lite.awprot  = PROT_DEFAULT;
    assign if_m_axi4_lite.wvalid  = wvalid_r;
    assign if_m_axi4_lite.wdata   = wdata_r;
    assign if_m_axi4_lite.wstrb   = wstrb_r;
    assign if_m_axi4_lite.bready  = bready_r;
    assign if_m_axi4_lite.arvalid = arvalid_r;
    assign if_m_axi4_lite.araddr  = addr_r;
    assign if_m_axi4_lite.arprot  = PROT_DEFAULT;
    assign if_m_axi4_lite.rready  = rready_r;

endmodule

// File: tb/tb_axi4_lite_cmd_mst.sv
// Self-checking bench: directed steps plus randomized traffic against a
// word-memory reference model and a configurable-latency slave.
module tb_axi4_lite_cmd_mst;
    import axi4_lite_cmd_mst_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmd_valid, i_cmd_we, i_rsp_ready;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wdata;
    logic [SW-1:0] i_cmd_wstrb;
    logic          o_cmd_ready, o_rsp_valid, o_rsp_we;
    logic [DW-1:0] o_rsp_rdata;
    logic [1:0]    o_rsp_resp;
    logic [15:0]   o_wr_cnt, o_rd_cnt;

    axi4_lite_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axi4_lite_cmd_mst #(
        .AXI4_LITE_ADDR_BIT_WIDTH(AW),
        .AXI4_LITE_DATA_BIT_WIDTH(DW)
    ) dut (
        .i_clk          (clk),
        .i_sync_rst     (rst),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_we       (i_cmd_we),
        .i_cmd_addr     (i_cmd_addr),
        .i_cmd_wdata    (i_cmd_wdata),
        .i_cmd_wstrb    (i_cmd_wstrb),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_we       (o_rsp_we),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_resp     (o_rsp_resp),
        .o_wr_cnt       (o_wr_cnt),
        .o_rd_cnt       (o_rd_cnt),
        .if_m_axi4_lite (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Slave configuration.
    int         cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
    logic [1:0] cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;

    // Handshake counts observed on the bus.
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

    // Slave internal state.
    int          aw_seen = 0, w_seen = 0, b_seen = 0, ar_seen = 0, r_seen = 0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
    logic [3:0]  aw_addr_q = 4'h0, ar_addr_q = 4'h0;
    logic [31:0] w_data_q = 32'h0;
    logic [3:0]  w_strb_q = 4'h0;
    logic [31:0] smem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

    // Reference model.
    logic [31:0] model_mem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [15:0] model_wr = 16'd0;
    logic [15:0] model_rd = 16'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Count handshakes at the active edge.
    always @(posedge clk) begin
        if (bus.awvalid && bus.awready) aw_hs++;
        if (bus.wvalid  && bus.wready)  w_hs++;
        if (bus.bvalid  && bus.bready)  b_hs++;
        if (bus.arvalid && bus.arready) ar_hs++;
        if (bus.rvalid  && bus.rready)  r_hs++;
    end

    // Slave responder, updated on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
            aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_seen = aw_hs; w_seen = w_hs; b_seen = b_hs; ar_seen = ar_hs; r_seen = r_hs;
        end else begin
            if (bus.awready) begin
                if (aw_hs != aw_seen) begin aw_seen = aw_hs; bus.awready = 1'b0; aw_got = 1'b1; aw_cnt = 0; end
            end else if (bus.awvalid && !aw_got) begin
                if (aw_cnt >= cfg_aw_dly) begin bus.awready = 1'b1; aw_addr_q = bus.awaddr; end
                else aw_cnt++;
            end
            if (bus.wready) begin
                if (w_hs != w_seen) begin w_seen = w_hs; bus.wready = 1'b0; w_got = 1'b1; w_cnt = 0; end
            end else if (bus.wvalid && !w_got) begin
                if (w_cnt >= cfg_w_dly) begin bus.wready = 1'b1; w_data_q = bus.wdata; w_strb_q = bus.wstrb; end
                else w_cnt++;
            end
            if (bus.bvalid) begin
                if (b_hs != b_seen) begin b_seen = b_hs; bus.bvalid = 1'b0; end
            end else if (aw_got && w_got) begin
                if (b_cnt >= cfg_b_dly) begin
                    bus.bvalid = 1'b1; bus.bresp = cfg_bresp;
                    if (cfg_bresp == RESP_OKAY)
                        for (int i = 0; i < 4; i++)
                            if (w_strb_q[i]) smem[aw_addr_q[3:2]][8*i +: 8] = w_data_q[8*i +: 8];
                    aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
                end else b_cnt++;
            end
            if (bus.arready) begin
                if (ar_hs != ar_seen) begin ar_seen = ar_hs; bus.arready = 1'b0; ar_got = 1'b1; ar_cnt = 0; end
            end else if (bus.arvalid && !ar_got) begin
                if (ar_cnt >= cfg_ar_dly) begin bus.arready = 1'b1; ar_addr_q = bus.araddr; end
                else ar_cnt++;
            end
            if (bus.rvalid) begin
                if (r_hs != r_seen) begin r_seen = r_hs; bus.rvalid = 1'b0; end
            end else if (ar_got) begin
                if (r_cnt >= cfg_r_dly) begin
                    bus.rvalid = 1'b1; bus.rdata = smem[ar_addr_q[3:2]]; bus.rresp = cfg_rresp;
                    ar_got = 1'b0; r_cnt = 0;
                end else r_cnt++;
            end
        end
    end

    // Issue one command, then check bus activity, response and counters.
    task automatic run_cmd(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int rsp_dly, input logic wfirst);
        logic [31:0] exp_rdata, mask;
        logic [1:0]  exp_resp;
        int          aw0, w0, b0, ar0, r0, n;
        if (we) begin
            exp_rdata = 32'h0;
            exp_resp  = cfg_bresp;
            mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
            if (!resp_is_error(cfg_bresp))
                model_mem[addr[3:2]] = (model_mem[addr[3:2]] & ~mask) | (wd & mask);
            model_wr = model_wr + 16'd1;
        end else begin
            exp_rdata = model_mem[addr[3:2]];
            exp_resp  = cfg_rresp;
            model_rd  = model_rd + 16'd1;
        end
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;

        n = 0;
        while (!o_cmd_ready && n < 20) begin @(negedge clk); n++; end
        check("cmd_ready_idle", o_cmd_ready, 1'b1);
        i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_addr = addr; i_cmd_wdata = wd; i_cmd_wstrb = ws;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        check("cmd_ready_busy", o_cmd_ready, 1'b0);
        check("awvalid_n1", bus.awvalid, we);
        check("wvalid_n1", bus.wvalid, we);
        check("arvalid_n1", bus.arvalid, !we);
        check("prot_zero", {bus.awprot, bus.arprot}, 6'b000000);
        if (we) begin
            check("awaddr", bus.awaddr, addr);
            check("wdata_wstrb", {bus.wdata, bus.wstrb}, {wd, ws});
        end else begin
            check("araddr", bus.araddr, addr);
        end

        if (wfirst) begin
            n = 0;
            while (w_hs == w0 && n < 50) begin @(negedge clk); n++; end
            check("w_first_hs", w_hs - w0, 1);
            check("w_first_wvalid_low", bus.wvalid, 1'b0);
            check("w_first_awvalid_held", bus.awvalid, 1'b1);
            check("w_first_no_aw_yet", aw_hs - aw0, 0);
        end

        n = 0;
        while (!o_rsp_valid && n < 200) begin @(negedge clk); n++; end
        check("rsp_valid_arrives", o_rsp_valid, 1'b1);
        if (!o_rsp_valid) return;
        check("rsp_payload", {o_rsp_we, o_rsp_resp, o_rsp_rdata}, {we, exp_resp, exp_rdata});
        check("wr_cnt", o_wr_cnt, model_wr);
        check("rd_cnt", o_rd_cnt, model_rd);
        check("no_bready_rready_in_rsp", {bus.bready, bus.rready}, 2'b00);

        for (int k = 0; k < rsp_dly; k++) begin
            @(negedge clk);
            check("rsp_hold_valid", o_rsp_valid, 1'b1);
            check("rsp_hold_payload", {o_rsp_we, o_rsp_resp, o_rsp_rdata}, {we, exp_resp, exp_rdata});
            check("rsp_hold_cmd_ready", o_cmd_ready, 1'b0);
        end
        i_rsp_ready = 1'b1;
        @(negedge clk);
        i_rsp_ready = 1'b0;
        check("rsp_consumed", o_rsp_valid, 1'b0);
        check("cmd_ready_again", o_cmd_ready, 1'b1);
        check("aw_hs_count", aw_hs - aw0, int'(we));
        check("w_hs_count",  w_hs - w0,   int'(we));
        check("b_hs_count",  b_hs - b0,   int'(we));
        check("ar_hs_count", ar_hs - ar0, int'(!we));
        check("r_hs_count",  r_hs - r0,   int'(!we));
    endtask

    // Hard time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Directed then randomized stimulus.
    initial begin
        logic [1:0] resp_tab [3];
        int n;
        resp_tab[0] = RESP_OKAY; resp_tab[1] = RESP_SLVERR; resp_tab[2] = RESP_DECERR;
        rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = 4'h0;
        i_cmd_wdata = 32'h0; i_cmd_wstrb = 4'h0; i_rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", o_cmd_ready, 1'b0);
        check("rst_bus_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b00000);
        check("rst_rsp", {o_rsp_valid, o_rsp_we, o_rsp_resp, o_rsp_rdata}, 36'h0);
        check("rst_cnts", {o_wr_cnt, o_rd_cnt}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", o_cmd_ready, 1'b1);

        // Basic write then read-back.
        run_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        run_cmd(1'b0, 4'h4, 32'h0, 4'h0, 0, 1'b0);

        // Address channel stalled well after the data channel.
        cfg_aw_dly = 5; cfg_w_dly = 0;
        run_cmd(1'b1, 4'h8, 32'h12345678, 4'h5, 0, 1'b1);
        cfg_aw_dly = 0;

        // Response back-pressure.
        run_cmd(1'b0, 4'h8, 32'h0, 4'h0, 10, 1'b0);

        // Reset while waiting for read data.
        cfg_r_dly = 30;
        n = 0;
        while (!o_cmd_ready && n < 20) begin @(negedge clk); n++; end
        i_cmd_valid = 1'b1; i_cmd_we = 1'b0; i_cmd_addr = 4'hC;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        n = 0;
        while (!bus.rready && n < 50) begin @(negedge clk); n++; end
        check("reached_rd_data", bus.rready, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_bus_idle", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b00000);
        check("mid_rst_no_rsp", o_rsp_valid, 1'b0);
        check("mid_rst_cmd_ready", o_cmd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_wr = 16'd0; model_rd = 16'd0;
        cfg_r_dly = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst_no_rsp", o_rsp_valid, 1'b0);
        end
        check("post_rst_cnts", {o_wr_cnt, o_rd_cnt}, 32'h0);
        run_cmd(1'b0, 4'h4, 32'h0, 4'h0, 1, 1'b0);

        // Write counter wrap with an error response (counter preloaded directly).
        @(negedge clk);
        dut.wr_cnt_r = 16'hFFFF;
        model_wr     = 16'hFFFF;
        cfg_bresp    = RESP_SLVERR;
        run_cmd(1'b1, 4'h0, 32'hCAFEF00D, 4'hF, 0, 1'b0);
        cfg_bresp    = RESP_OKAY;
        run_cmd(1'b0, 4'h0, 32'h0, 4'h0, 0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            cfg_aw_dly = $urandom_range(0, 3);
            cfg_w_dly  = $urandom_range(0, 3);
            cfg_b_dly  = $urandom_range(0, 3);
            cfg_ar_dly = $urandom_range(0, 3);
            cfg_r_dly  = $urandom_range(0, 3);
            cfg_bresp  = resp_tab[$urandom_range(0, 2)];
            cfg_rresp  = resp_tab[$urandom_range(0, 2)];
            run_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
